taus88_reader: RTL
==================

Name: taus88_reader

Overview:
- Consumer-side controller for the taus88 generator: drives its seed/re_seed inputs and reads its rnd output.
- Sequences a reseed, discards the settle cycles, then captures every fresh word into a small FIFO.
- Presents the captured words on a valid/ready stream toward stochastic-number generators downstream.
- Counts words lost when the downstream stalls, because the generator free-runs and cannot be paused.

Parameters:
- WIDTH, 32, rnd/seed word width
- SETTLE_CYCLES, 2, cycles discarded after the re_seed pulse before capture begins (at least 1)
- FIFO_DEPTH, 4, capture FIFO entries (power of two, at least 2)
- DROP_W, 16, drop counter width

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_seed  in  WIDTH  seed value, sampled when cfg_reseed_req=1
- cfg_reseed_req  in  1  single-cycle reseed request
- cfg_busy  out  1  high in SEED and SETTLE
- rng_seed  out  WIDTH  to the generator's seed input
- rng_re_seed  out  1  to the generator's re_seed input
- rng_rnd  in  WIDTH  from the generator's rnd output
- m_valid  out  1  FIFO not empty
- m_ready  in  1  downstream accept
- m_data  out  WIDTH  FIFO head word
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- drop_cnt  out  DROP_W  saturating count of words lost since the last reseed

Behaviour:
- Reset (async, active-low) forces every register to its reset value:
  - FSM=IDLE, FIFO empty
  - m_valid=0, m_data=0, level=0, drop_cnt=0
  - rng_re_seed=0, rng_seed=0, cfg_busy=0
- FSM states: IDLE, SEED, SETTLE, RUN.
- IDLE: no capture. cfg_reseed_req moves the FSM to SEED.
- Entering SEED from any state:
  - latch cfg_seed into the rng_seed register
  - flush the FIFO
  - clear drop_cnt and the settle counter
- SEED: lasts exactly one cycle with rng_re_seed=1, then moves to SETTLE.
- SETTLE:
  - rng_re_seed=0; rng_rnd is ignored
  - after SETTLE_CYCLES cycles, move to RUN
- RUN, every cycle:
  - push = !full || (m_ready && m_valid)
  - if push, rng_rnd is written to the FIFO tail
  - otherwise drop_cnt increments, saturating at all-ones
- Stream handshake:
  - a pop occurs when m_valid && m_ready
  - m_data and m_valid hold stable while m_valid=1 and m_ready=0
- FIFO boundary cases:
  - push and pop in the same cycle: level unchanged, including at full
  - pop when empty: impossible (m_valid=0)
  - pointers wrap modulo FIFO_DEPTH
- Latency:
  - a word pushed in cycle N is visible on m_data in cycle N+1 if the FIFO was empty
  - cfg_reseed_req in cycle N gives rng_re_seed=1 in cycle N+1
  - the first capture happens in cycle N+2+SETTLE_CYCLES
- Reseed during any state, including SEED, SETTLE or RUN, restarts the sequence at SEED with the new seed:
  - unread FIFO words are discarded
  - a pop asserted in that same cycle is ignored
- cfg_busy = (state==SEED || state==SETTLE).
- rng_seed holds the last latched seed until the next reseed.

Decomposition:
- Package taus88_reader_pkg holds:
  - the state enum (IDLE/SEED/SETTLE/RUN)
  - default WIDTH, SETTLE_CYCLES and FIFO_DEPTH constants
- One sub-module, sync_fifo: synchronous FIFO with push, pop, flush, full, empty and level, parameterised by WIDTH and DEPTH, using the same clk/rst_n.
- The FSM, settle counter and drop counter live in the top level.

Test Plan:
1. Reset, then 10 cycles with no request -> m_valid=0, level=0, rng_re_seed=0, drop_cnt=0 throughout.
2. Reseed 0xDEADBEEF with the real taus88 attached and m_ready=1 -> m_data over successive valid cycles is 3687771566, 4006792393, 1712068217, 3375142808, 1509541458, 45559123, 4065404862, 49953709, 2327600246, 3851033654.
3. Reseed 0xCAFEBABE with m_ready=1 -> the first three words are 3951813429, 3191570171, 4247730860; rng_re_seed is high for exactly one cycle; cfg_busy is high for 1+SETTLE_CYCLES=3 cycles.
4. Reseed 0xDEADBEEF with m_ready=0 for 10 RUN cycles:
   - level reaches 4 and holds
   - drop_cnt=6
   - after raising m_ready, the first 4 words are 3687771566, 4006792393, 1712068217, 3375142808
5. Full FIFO with m_ready=1 -> push and pop in the same cycle, level stays 4, drop_cnt does not change.
6. Reseed 0xCAFEBABE issued mid-RUN with level=3, then a second request with 0xDEADBEEF during SETTLE:
   - FIFO flushed, drop_cnt=0
   - the first word out is 3687771566

Source files
------------

// File: rtl/taus88_reader_pkg.sv
// Shared types and default sizing for the taus88 reader controller.
package taus88_reader_pkg;

   // Controller sequence: idle until the first reseed, then seed pulse,
   // settle (discard generator output), then continuous capture.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEED   = 2'd1,
      ST_SETTLE = 2'd2,
      ST_RUN    = 2'd3
   } state_t;

   localparam int DEF_WIDTH         = 32;
   localparam int DEF_SETTLE_CYCLES = 2;
   localparam int DEF_FIFO_DEPTH    = 4;
   localparam int DEF_DROP_W        = 16;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush. The head word is read combinationally
// from the storage registers so a word written into an empty FIFO shows up
// on rd_data in the very next cycle. Flush wins over push and pop.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic [DEPTH-1:0] wr_en;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign level   = count_reg;
   assign rd_data = mem_reg[rd_ptr_reg];

   // A push into a full FIFO is only legal when the head leaves the same cycle.
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && (!full || do_pop) && !flush;

   // One write-enable per storage slot, selected by the write pointer.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
         assign wr_en[gi] = do_push && (wr_ptr_reg == AW'(gi));
      end
   endgenerate

   // Storage: write the selected slot; contents are not cleared by flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
               mem_reg[i] <= wr_data;
            end
         end
      end
   end

   // Pointers (wrap naturally at DEPTH) and occupancy count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (do_push && !do_pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (do_pop && !do_push) begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

endmodule

// File: rtl/taus88_reader.sv
// Consumer-side controller for a free-running taus88 generator: issues the
// seed/re_seed pulse, discards the settle cycles, captures each fresh word
// into a FIFO and streams it out, counting words lost to downstream stalls.
module taus88_reader
   import taus88_reader_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
   parameter int DROP_W        = DEF_DROP_W
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [WIDTH-1:0]              cfg_seed,
   input  logic                          cfg_reseed_req,
   output logic                          cfg_busy,
   output logic [WIDTH-1:0]              rng_seed,
   output logic                          rng_re_seed,
   input  logic [WIDTH-1:0]              rng_rnd,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [WIDTH-1:0]              m_data,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic [DROP_W-1:0]             drop_cnt
);

   localparam int SCW = $clog2(SETTLE_CYCLES + 1);

   state_t           state_reg, state_next;
   logic [SCW-1:0]   settle_cnt_reg, settle_cnt_next;
   logic [WIDTH-1:0] seed_reg;
   logic [DROP_W-1:0] drop_cnt_reg;

   logic fifo_full;
   logic fifo_empty;
   logic push;
   logic pop;
   logic drop_inc;

   // A reseed request overrides everything: the same-cycle pop is ignored and
   // the FIFO is flushed instead of written.
   assign pop      = m_valid && m_ready && !cfg_reseed_req;
   assign push     = (state_reg == ST_RUN) && !cfg_reseed_req && (!fifo_full || pop);
   assign drop_inc = (state_reg == ST_RUN) && !cfg_reseed_req && !push;

   assign m_valid     = !fifo_empty;
   assign rng_re_seed = (state_reg == ST_SEED);
   assign cfg_busy    = (state_reg == ST_SEED) || (state_reg == ST_SETTLE);
   assign rng_seed    = seed_reg;
   assign drop_cnt    = drop_cnt_reg;

   // Next-state and settle-counter logic.
   always_comb begin
      state_next      = state_reg;
      settle_cnt_next = settle_cnt_reg;
      if (cfg_reseed_req) begin
         state_next      = ST_SEED;
         settle_cnt_next = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               state_next = ST_IDLE;
            end
            ST_SEED: begin
               state_next      = ST_SETTLE;
               settle_cnt_next = '0;
            end
            ST_SETTLE: begin
               if (settle_cnt_reg == SCW'(SETTLE_CYCLES - 1)) begin
                  state_next = ST_RUN;
               end else begin
                  settle_cnt_next = settle_cnt_reg + 1'b1;
               end
            end
            ST_RUN: begin
               state_next = ST_RUN;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // State and settle-counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         settle_cnt_reg <= '0;
      end else begin
         state_reg      <= state_next;
         settle_cnt_reg <= settle_cnt_next;
      end
   end

   // Seed latch: holds the last requested seed for the generator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seed_reg <= '0;
      end else if (cfg_reseed_req) begin
         seed_reg <= cfg_seed;
      end
   end

   // Saturating count of generator words lost while the FIFO was full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_reg <= '0;
      end else if (cfg_reseed_req) begin
         drop_cnt_reg <= '0;
      end else if (drop_inc && (drop_cnt_reg != '1)) begin
         drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
   end

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (cfg_reseed_req),
      .push    (push),
      .pop     (pop),
      .wr_data (rng_rnd),
      .rd_data (m_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

endmodule
